fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage RISC-V pipeline inside `CPU`. It owns the program counter, issues requests on a variable-latency instruction-memory port, and loads the IF/ID pipeline register consumed by the decode stage. It also honours load-use stalls from the hazard unit and taken-branch/jump redirects from EX. A one-entry skid buffer absorbs an instruction that returns while decode is stalled.

---
 rtl/fetch_stage.sv | 129 ++++++++++++
 tb/tb_fetch_stage.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks to a variable-latency instruction memory,
// and loads the IF/ID register, with a one-entry skid buffer for words returning under stall.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_instr
);

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] drain_target, drain_target_n;
    logic        buf_valid, buf_valid_n;
    logic [31:0] buf_pc, buf_pc_n;
    logic [31:0] buf_instr, buf_instr_n;
    logic        if_id_valid_n;
    logic [31:0] if_id_pc_n, if_id_instr_n;

    logic        accept;
    logic [31:0] target;
    logic [31:0] pc_plus4;

    assign target    = {redirect_target[31:2], 2'b00};
    assign pc_plus4  = pc + 32'd4;
    // In DRAIN the buffer is always empty, so the request stays up until the stale word lands.
    assign imem_req  = (state == DRAIN) || !buf_valid;
    assign imem_addr = pc;
    assign accept    = imem_req && imem_ready;
    assign if_id_pc4 = if_id_pc + 32'd4;

    // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
    always_comb begin
        state_n        = state;
        pc_n           = pc;
        drain_target_n = drain_target;
        buf_valid_n    = buf_valid;
        buf_pc_n       = buf_pc;
        buf_instr_n    = buf_instr;
        if_id_valid_n  = if_id_valid;
        if_id_pc_n     = if_id_pc;
        if_id_instr_n  = if_id_instr;

        if (redirect_valid) begin
            if_id_valid_n = 1'b0;
            if_id_instr_n = NOP_INSTR;
            buf_valid_n   = 1'b0;
            if (imem_req && !imem_ready) begin
                // The pending request must complete at its old address before the target is issued.
                state_n        = DRAIN;
                drain_target_n = target;
            end else begin
                state_n = FETCH;
                pc_n    = target;
            end
        end else if (state == DRAIN) begin
            if (accept) begin
                state_n = FETCH;
                pc_n    = drain_target;
            end
            if (!stall) begin
                if_id_valid_n = 1'b0;
                if_id_instr_n = NOP_INSTR;
            end
        end else if (stall) begin
            if (accept) begin
                buf_valid_n = 1'b1;
                buf_pc_n    = pc;
                buf_instr_n = imem_rdata;
                pc_n        = pc_plus4;
            end
        end else if (buf_valid) begin
            if_id_valid_n = 1'b1;
            if_id_pc_n    = buf_pc;
            if_id_instr_n = buf_instr;
            buf_valid_n   = 1'b0;
        end else if (accept) begin
            if_id_valid_n = 1'b1;
            if_id_pc_n    = pc;
            if_id_instr_n = imem_rdata;
            pc_n          = pc_plus4;
        end else begin
            if_id_valid_n = 1'b0;
            if_id_instr_n = NOP_INSTR;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= FETCH;
            pc           <= RESET_PC;
            drain_target <= RESET_PC;
            buf_valid    <= 1'b0;
            buf_pc       <= 32'h0;
            buf_instr    <= NOP_INSTR;
            if_id_valid  <= 1'b0;
            if_id_pc     <= 32'h0;
            if_id_instr  <= NOP_INSTR;
        end else begin
            state        <= state_n;
            pc           <= pc_n;
            drain_target <= drain_target_n;
            buf_valid    <= buf_valid_n;
            buf_pc       <= buf_pc_n;
            buf_instr    <= buf_instr_n;
            if_id_valid  <= if_id_valid_n;
            if_id_pc     <= if_id_pc_n;
            if_id_instr  <= if_id_instr_n;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random traffic, checked against a
// queue-based model of the fetch stream and a scoreboard of instructions handed to decode.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, stall, redirect_valid, imem_ready;
    logic [31:0] redirect_target, imem_rdata;
    logic        imem_req, if_id_valid;
    logic [31:0] imem_addr, if_id_pc, if_id_pc4, if_id_instr;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
        .if_id_pc4(if_id_pc4), .if_id_instr(if_id_instr)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    // Model: fetch pointer, optional stale request being drained, words fetched but not yet in decode.
    entry_t      fetched_q[$];
    entry_t      expect_q[$];
    entry_t      m_cur;
    logic [31:0] m_next = 32'h0;
    logic [31:0] m_after = 32'h0;
    bit          m_discard = 1'b0;
    bit          m_valid = 1'b0;
    bit          advanced = 1'b0;
    bit          started = 1'b0;

    function automatic bit m_req();
        return m_discard || (fetched_q.size() == 0);
    endfunction

    // Applies the edge just taken with the inputs that were driven for it.
    task automatic model_step();
        bit     req;
        bit     acc;
        entry_t e;
        req = m_req();
        acc = req && imem_ready;
        if (rst) begin
            m_next    = 32'h0;
            m_discard = 1'b0;
            m_valid   = 1'b0;
            fetched_q.delete();
            advanced  = 1'b1;
            started   = 1'b1;
        end else begin
            advanced = !stall || redirect_valid;
            if (redirect_valid) begin
                fetched_q.delete();
                m_valid = 1'b0;
                if (req && !imem_ready) begin
                    m_discard = 1'b1;
                    m_after   = redirect_target & 32'hFFFF_FFFC;
                end else begin
                    m_discard = 1'b0;
                    m_next    = redirect_target & 32'hFFFF_FFFC;
                end
            end else if (m_discard) begin
                if (acc) begin
                    m_discard = 1'b0;
                    m_next    = m_after;
                end
                if (!stall) m_valid = 1'b0;
            end else begin
                if (acc) begin
                    e.pc    = m_next;
                    e.instr = mem_word(m_next);
                    fetched_q.push_back(e);
                    m_next  = m_next + 32'd4;
                end
                if (!stall) begin
                    if (fetched_q.size() > 0) begin
                        m_cur   = fetched_q.pop_front();
                        m_valid = 1'b1;
                        expect_q.push_back(m_cur);
                    end else begin
                        m_valid = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic cyc(input bit s, input bit r, input logic [31:0] t, input bit rdy);
        stall           = s;
        redirect_valid  = r;
        redirect_target = t;
        imem_ready      = rdy;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        rst = 1'b0;
    endtask

    task automatic check_reset_state();
        check("rst_valid", {31'h0, if_id_valid}, 32'h0);
        check("rst_instr", if_id_instr, NOP);
        check("rst_pc", if_id_pc, 32'h0);
        check("rst_pc4", if_id_pc4, 32'h4);
        check("rst_req", {31'h0, imem_req}, 32'h1);
        check("rst_addr", imem_addr, 32'h0);
    endtask

    // Monitor: compares DUT outputs against the model mid-cycle; pops the scoreboard on each new instruction.
    initial begin
        entry_t e;
        forever begin
            @(negedge clk);
            if (started) begin
                check("imem_req", {31'h0, imem_req}, {31'h0, m_req()});
                if (m_req()) check("imem_addr", imem_addr, m_next);
                check("if_id_valid", {31'h0, if_id_valid}, {31'h0, m_valid});
                if (!m_valid) begin
                    check("bubble_instr", if_id_instr, NOP);
                end else if (advanced) begin
                    if (expect_q.size() > 0) begin
                        e = expect_q.pop_front();
                        check("sb_pc", if_id_pc, e.pc);
                        check("sb_instr", if_id_instr, e.instr);
                        check("sb_pc4", if_id_pc4, e.pc + 32'd4);
                    end
                end else begin
                    check("held_pc", if_id_pc, m_cur.pc);
                    check("held_instr", if_id_instr, m_cur.instr);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
        redirect_target = 32'h0; imem_ready = 1'b1;
        do_reset();
        check_reset_state();

        // Straight-line fetch.
        idle(6);

        // Memory not ready for three cycles at address 8.
        do_reset();
        idle(2);
        for (int i = 0; i < 3; i++) begin
            check("hold_addr", imem_addr, 32'h8);
            cyc(1'b0, 1'b0, 32'h0, 1'b0);
        end
        idle(4);

        // Decode stall while IF/ID holds pc 4: buffer fills, request drops.
        do_reset();
        idle(2);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'h0, 1'b1);
        check("stall_hold_pc", if_id_pc, 32'h4);
        check("stall_req_low", {31'h0, imem_req}, 32'h0);
        idle(4);

        // Redirect with misaligned target bits.
        cyc(1'b0, 1'b1, 32'h0000_0103, 1'b1);
        check("redir_addr", imem_addr, 32'h100);
        idle(3);

        // Redirect while a request at 0x40 is outstanding, then re-redirect during DRAIN.
        cyc(1'b0, 1'b1, 32'h40, 1'b1);
        cyc(1'b0, 1'b1, 32'h200, 1'b0);
        check("drain_addr", imem_addr, 32'h40);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b1, 32'h300, 1'b0);
        check("drain_addr2", imem_addr, 32'h40);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        check("drain_next", imem_addr, 32'h300);
        idle(3);

        // Reset during DRAIN, then reset with a full buffer.
        cyc(1'b0, 1'b1, 32'h500, 1'b0);
        do_reset();
        check_reset_state();
        idle(1);
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        do_reset();
        check_reset_state();

        // Address wrap at the top of memory.
        cyc(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        idle(1);
        check("wrap_addr1", imem_addr, 32'h0);
        idle(3);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(299) == 0);
            cyc($urandom_range(99) < 30, $urandom_range(99) < 6, $urandom, $urandom_range(99) < 65);
        end
        rst = 1'b0;
        idle(4);

        @(negedge clk);
        #1;
        check("sb_empty", expect_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
